// File: rtl/spmv_sram_rd_arbiter.sv
// ============================================================================
// spmv_sram_rd_arbiter : shares one SRAM read port between two burst readers
// Optional: SPMV_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins)
// Revision: 1.0
// ============================================================================
`default_nettype none

module spmv_sram_rd_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 256,
  parameter int LEN_W  = 4,
  parameter int RD_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_req0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [LEN_W-1:0]  i_len0,
  output logic              o_gnt0,
  output logic              o_rvalid0,
  output logic              o_rlast0,
  input  logic              i_req1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [LEN_W-1:0]  i_len1,
  output logic              o_gnt1,
  output logic              o_rvalid1,
  output logic              o_rlast1,
  output logic              o_sram_rden,
  output logic [ADDR_W-1:0] o_sram_addr,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic [DATA_W-1:0] o_rdata
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic              owner_q, owner_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              rden_q, rden_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic w_arb_en, w_pick1, w_gnt0, w_gnt1;

  // cnt_q holds beats remaining after the one on the SRAM port this cycle
  assign w_arb_en = i_rstn && ((state_q == IDLE) || (cnt_q == '0));
  assign w_pick1  = i_req1 && (!i_req0 || rr_q);
  assign w_gnt1   = w_arb_en && w_pick1;
  assign w_gnt0   = w_arb_en && i_req0 && !w_pick1;

  assign o_gnt0 = w_gnt0;
  assign o_gnt1 = w_gnt1;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rden_d  = rden_q;
    addr_d  = addr_q;
    if ((state_q == BURST) && (cnt_q != '0)) begin
      cnt_d  = cnt_q - LEN_W'(1);
      addr_d = addr_q + ADDR_W'(1);
    end else if (w_gnt0 || w_gnt1) begin
      state_d = BURST;
      rden_d  = 1'b1;
      owner_d = w_gnt1;
      addr_d  = w_gnt1 ? i_addr1 : i_addr0;
      cnt_d   = w_gnt1 ? i_len1 : i_len0;
`ifdef SPMV_ARB_FIXED_PRIO_EN
      rr_d    = 1'b0;
`else
      rr_d    = !w_gnt1;
`endif
    end else begin
      state_d = IDLE;
      rden_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      rden_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rden_q  <= rden_d;
      addr_q  <= addr_d;
    end
  end

  assign o_sram_rden = rden_q;
  assign o_sram_addr = addr_q;
  assign o_rdata     = i_sram_rdata;

  // Tag = {valid, owner, last}; final stage is the decoded output register
  logic [2:0] w_tag_in, w_tag_tail;
  assign w_tag_in = {rden_q, owner_q, (cnt_q == '0)};

  generate
    if (RD_LAT > 1) begin : g_tag_pipe
      logic [2:0] pipe_q [RD_LAT-1];
      always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
          for (int i = 0; i < RD_LAT - 1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= w_tag_in;
          for (int i = 1; i < RD_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign w_tag_tail = pipe_q[RD_LAT-2];
    end else begin : g_tag_direct
      assign w_tag_tail = w_tag_in;
    end
  endgenerate

  logic rvalid0_q, rlast0_q, rvalid1_q, rlast1_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      rvalid0_q <= 1'b0;
      rlast0_q  <= 1'b0;
      rvalid1_q <= 1'b0;
      rlast1_q  <= 1'b0;
    end else begin
      rvalid0_q <= w_tag_tail[2] && !w_tag_tail[1];
      rlast0_q  <= w_tag_tail[2] && !w_tag_tail[1] && w_tag_tail[0];
      rvalid1_q <= w_tag_tail[2] && w_tag_tail[1];
      rlast1_q  <= w_tag_tail[2] && w_tag_tail[1] && w_tag_tail[0];
    end
  end

  assign o_rvalid0 = rvalid0_q;
  assign o_rlast0  = rlast0_q;
  assign o_rvalid1 = rvalid1_q;
  assign o_rlast1  = rlast1_q;

endmodule

`default_nettype wire

// File: tb/tb_spmv_sram_rd_arbiter.sv
// ============================================================================
// tb_spmv_sram_rd_arbiter : directed self-checking bench for the read arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spmv_sram_rd_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 256;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic              req0, req1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [LEN_W-1:0]  len0, len1;
  logic              gnt0, gnt1, rvalid0, rlast0, rvalid1, rlast1;
  logic              sram_rden;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_rdata, rdata;

  int n_total = 0;
  int n_pass  = 0;

  spmv_sram_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .RD_LAT(2)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_req0(req0), .i_addr0(addr0), .i_len0(len0), .o_gnt0(gnt0),
    .o_rvalid0(rvalid0), .o_rlast0(rlast0),
    .i_req1(req1), .i_addr1(addr1), .i_len1(len1), .o_gnt1(gnt1),
    .o_rvalid1(rvalid1), .o_rlast1(rlast1),
    .o_sram_rden(sram_rden), .o_sram_addr(sram_addr),
    .i_sram_rdata(sram_rdata), .o_rdata(rdata)
  );

  always #5 clk = ~clk;

  // Two-cycle SRAM model: data encodes the address that was read
  logic [ADDR_W-1:0] sa1, sa2;
  always @(posedge clk) begin
    sa1 <= sram_addr;
    sa2 <= sa1;
  end
  assign sram_rdata = {16{6'h2A, sa2}};

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return {16{6'h2A, a}};
  endfunction

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Checks all registered outputs for one cycle; address only while reading
  task automatic chk_out(input string tag, input logic e_rden, input logic [ADDR_W-1:0] e_addr,
                         input logic e_rv0, input logic e_rl0, input logic e_rv1, input logic e_rl1);
    check({tag, ".rden"}, DATA_W'(sram_rden), DATA_W'(e_rden));
    if (e_rden) check({tag, ".addr"}, DATA_W'(sram_addr), DATA_W'(e_addr));
    check({tag, ".rv0"}, DATA_W'(rvalid0), DATA_W'(e_rv0));
    check({tag, ".rl0"}, DATA_W'(rlast0), DATA_W'(e_rl0));
    check({tag, ".rv1"}, DATA_W'(rvalid1), DATA_W'(e_rv1));
    check({tag, ".rl1"}, DATA_W'(rlast1), DATA_W'(e_rl1));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
    cyc(); cyc();
    rstn = 1'b1;
    cyc();
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    do_reset();
    chk_out("rst", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst.addr", DATA_W'(sram_addr), '0);
    check("rst.gnt0", DATA_W'(gnt0), '0);

    // 1: single-beat burst from requester 0
    req0 = 1'b1; addr0 = 10'h010; len0 = 4'd0; #1;
    check("t1.gnt0", DATA_W'(gnt0), 1);
    check("t1.gnt1", DATA_W'(gnt1), 0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      req0 = 1'b0;
      chk_out($sformatf("t1.c%0d", k), k == 1, 10'h010, k == 3, k == 3, 1'b0, 1'b0);
      if (k == 3) check("t1.rdata", rdata, pat(10'h010));
    end

    // 2: four-beat burst from requester 1
    req1 = 1'b1; addr1 = 10'h100; len1 = 4'd3; #1;
    check("t2.gnt1", DATA_W'(gnt1), 1);
    check("t2.gnt0", DATA_W'(gnt0), 0);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      req1 = 1'b0;
      a = 10'h100 + ADDR_W'(k - 1);
      chk_out($sformatf("t2.c%0d", k), k <= 4, a, 1'b0, 1'b0, k >= 3 && k <= 6, k == 6);
      if (k == 4) check("t2.rdata", rdata, pat(10'h101));
    end

    // 3: simultaneous requests after reset, back-to-back bursts
    do_reset();
    req0 = 1'b1; addr0 = 10'h020; len0 = 4'd1;
    req1 = 1'b1; addr1 = 10'h040; len1 = 4'd1; #1;
    check("t3.gnt0", DATA_W'(gnt0), 1);
    check("t3.gnt1.c0", DATA_W'(gnt1), 0);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      req0 = 1'b0;
      if (k == 3) req1 = 1'b0;
      #1;
      if (k == 1) check("t3.gnt1.c1", DATA_W'(gnt1), 0);
      if (k == 2) check("t3.gnt1.c2", DATA_W'(gnt1), 1);
      a = (k <= 2) ? 10'h020 + ADDR_W'(k - 1) : 10'h040 + ADDR_W'(k - 3);
      chk_out($sformatf("t3.c%0d", k), k <= 4, a, k == 3 || k == 4, k == 4, k == 5 || k == 6, k == 6);
    end

    // 4: address wrap at the top of the SRAM
    req0 = 1'b1; addr0 = 10'h3FE; len0 = 4'd3; #1;
    check("t4.gnt0", DATA_W'(gnt0), 1);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      req0 = 1'b0;
      a = 10'h3FE + ADDR_W'(k - 1);
      chk_out($sformatf("t4.c%0d", k), 1'b1, a, k >= 3, 1'b0, 1'b0, 1'b0);
    end
    check("t4.a3", DATA_W'(sram_addr), 10'h001);
    repeat (4) cyc();

    // 5: reset during the second beat of an eight-beat burst
    req0 = 1'b1; addr0 = 10'h200; len0 = 4'd7; #1;
    check("t5.gnt0", DATA_W'(gnt0), 1);
    cyc();
    cyc();
    check("t5.beat2", DATA_W'(sram_addr), 10'h201);
    rstn = 1'b0; req0 = 1'b1; #1;
    check("t5.gnt_rst", DATA_W'(gnt0), 0);
    cyc();
    chk_out("t5.after", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b1; req0 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk_out($sformatf("t5.idle%0d", k), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    req1 = 1'b1; addr1 = 10'h0AA; len1 = 4'd0; #1;
    check("t5.gnt1", DATA_W'(gnt1), 1);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      req1 = 1'b0;
      chk_out($sformatf("t5.new%0d", k), k == 1, 10'h0AA, 1'b0, 1'b0, k == 3, k == 3);
      if (k == 3) check("t5.rdata", rdata, pat(10'h0AA));
    end

    // 6: both requesters held with single-beat bursts
    do_reset();
    req0 = 1'b1; addr0 = 10'h050; len0 = 4'd0;
    req1 = 1'b1; addr1 = 10'h060; len1 = 4'd0;
    for (int k = 0; k < 6; k++) begin
      #1;
`ifdef SPMV_ARB_FIXED_PRIO_EN
      check($sformatf("t6.gnt0.%0d", k), DATA_W'(gnt0), 1);
      check($sformatf("t6.gnt1.%0d", k), DATA_W'(gnt1), 0);
`else
      check($sformatf("t6.gnt0.%0d", k), DATA_W'(gnt0), DATA_W'(k % 2 == 0));
      check($sformatf("t6.gnt1.%0d", k), DATA_W'(gnt1), DATA_W'(k % 2 == 1));
`endif
      cyc();
      if (k > 0) check($sformatf("t6.rden.%0d", k), DATA_W'(sram_rden), 1);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
